// File: rtl/uart_bus_loader_pkg.sv
// Shared constants and state encodings for the UART-driven bus loader.
package uart_bus_loader_pkg;

    localparam logic [7:0] CmdWrite = 8'h57;
    localparam logic [7:0] CmdGo    = 8'h47;
    localparam logic [7:0] CmdHalt  = 8'h48;

    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS_REQ, BUS_WAIT} parse_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/uart_bus_loader_uart_rx.sv
// 8N1 UART receiver: input synchroniser, mid-bit sampling, byte and framing-error strobes.
module uart_rx
    import uart_bus_loader_pkg::*;
#(
    parameter int ClksPerBit = 434
) (
    input  logic       clk_sys_i,
    input  logic       rst_sys_ni,
    input  logic       rx_i,
    output logic       rx_valid_o,
    output logic [7:0] rx_data_o,
    output logic       rx_frame_err_o
);
    localparam int CntW = $clog2(ClksPerBit + 1);
    localparam logic [CntW-1:0] HalfBit = CntW'(ClksPerBit / 2 - 1);
    localparam logic [CntW-1:0] FullBit = CntW'(ClksPerBit - 1);

    rx_state_e       state_r, state_s;
    logic [CntW-1:0] cnt_r, cnt_s;
    logic [2:0]      bit_r, bit_s;
    logic [7:0]      shift_r, shift_s;
    logic            meta_r, sync_r, prev_r;
    logic            valid_r, valid_s, ferr_r, ferr_s;

    // Synchroniser, edge history and receiver state registers
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            meta_r  <= 1'b1;
            sync_r  <= 1'b1;
            prev_r  <= 1'b1;
            state_r <= RX_IDLE;
            cnt_r   <= '0;
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
        end else begin
            meta_r  <= rx_i;
            sync_r  <= meta_r;
            prev_r  <= sync_r;
            state_r <= state_s;
            cnt_r   <= cnt_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            valid_r <= valid_s;
            ferr_r  <= ferr_s;
        end
    end

    // Bit timing and frame decode
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r + CntW'(1);
        bit_s   = bit_r;
        shift_s = shift_r;
        valid_s = 1'b0;
        ferr_s  = 1'b0;
        case (state_r)
            RX_IDLE: begin
                cnt_s = '0;
                if (prev_r && !sync_r) state_s = RX_START;
                else                   state_s = RX_IDLE;
            end
            RX_START: begin
                if (cnt_r == HalfBit) begin
                    cnt_s   = '0;
                    bit_s   = 3'd0;
                    // a high line mid start bit was only a glitch
                    state_s = sync_r ? RX_IDLE : RX_DATA;
                end else begin
                    state_s = RX_START;
                end
            end
            RX_DATA: begin
                if (cnt_r == FullBit) begin
                    cnt_s   = '0;
                    shift_s = {sync_r, shift_r[7:1]};
                    bit_s   = bit_r + 3'd1;
                    if (bit_r == 3'd7) state_s = RX_STOP;
                    else               state_s = RX_DATA;
                end else begin
                    state_s = RX_DATA;
                end
            end
            RX_STOP: begin
                if (cnt_r == FullBit) begin
                    cnt_s   = '0;
                    valid_s = sync_r;
                    ferr_s  = !sync_r;
                    state_s = RX_IDLE;
                end else begin
                    state_s = RX_STOP;
                end
            end
            default: begin
                cnt_s   = '0;
                state_s = RX_IDLE;
            end
        endcase
    end

    assign rx_valid_o     = valid_r;
    assign rx_data_o      = shift_r;
    assign rx_frame_err_o = ferr_r;

endmodule

// File: rtl/uart_bus_loader.sv
// UART command parser driving single-word bus writes and the core hold line.
module uart_bus_loader
    import uart_bus_loader_pkg::*;
#(
    parameter int   ClockFrequency = 50_000_000,
    parameter int   BaudRate       = 115_200,
    parameter int   TimeoutCycles  = 1_000_000,
    parameter logic HoldAtReset    = 1'b1
) (
    input  logic        clk_sys_i,
    input  logic        rst_sys_ni,
    input  logic        uart_rx_i,
    output logic        host_req_o,
    input  logic        host_gnt_i,
    output logic [31:0] host_addr_o,
    output logic        host_we_o,
    output logic [3:0]  host_be_o,
    output logic [31:0] host_wdata_o,
    input  logic        host_rvalid_i,
    input  logic        host_err_i,
    output logic        core_hold_o,
    output logic        err_o
);
    localparam int ClksPerBit = ClockFrequency / BaudRate;
    localparam int TmoW       = $clog2(TimeoutCycles + 1);
    localparam logic [TmoW-1:0] TmoMax = TmoW'(TimeoutCycles);

    parse_state_e    state_r, state_s;
    logic [1:0]      byte_cnt_r, byte_cnt_s;
    logic [31:0]     addr_r, addr_s, wdata_r, wdata_s;
    logic [TmoW-1:0] tmo_r, tmo_s;
    logic            req_r, req_s, hold_r, hold_s, err_r, err_s;
    logic            rx_valid_s, rx_ferr_s, collecting_s;
    logic [7:0]      rx_data_s;

    uart_rx #(.ClksPerBit(ClksPerBit)) u_rx (
        .clk_sys_i     (clk_sys_i),
        .rst_sys_ni    (rst_sys_ni),
        .rx_i          (uart_rx_i),
        .rx_valid_o    (rx_valid_s),
        .rx_data_o     (rx_data_s),
        .rx_frame_err_o(rx_ferr_s)
    );

    // Parser, payload, timeout and bus-host registers
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            state_r    <= IDLE;
            byte_cnt_r <= 2'd0;
            addr_r     <= 32'h0000_0000;
            wdata_r    <= 32'h0000_0000;
            tmo_r      <= '0;
            req_r      <= 1'b0;
            hold_r     <= HoldAtReset;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            byte_cnt_r <= byte_cnt_s;
            addr_r     <= addr_s;
            wdata_r    <= wdata_s;
            tmo_r      <= tmo_s;
            req_r      <= req_s;
            hold_r     <= hold_s;
            err_r      <= err_s;
        end
    end

    // Command decode, payload assembly and bus handshake
    always_comb begin
        state_s      = state_r;
        byte_cnt_s   = byte_cnt_r;
        addr_s       = addr_r;
        wdata_s      = wdata_r;
        req_s        = req_r;
        hold_s       = hold_r;
        err_s        = err_r;
        collecting_s = (state_r == ADDR) || (state_r == DATA);
        if (!collecting_s || rx_valid_s) tmo_s = '0;
        else if (tmo_r == TmoMax)        tmo_s = tmo_r;
        else                             tmo_s = tmo_r + TmoW'(1);
        case (state_r)
            IDLE: begin
                if (rx_valid_s) begin
                    if (rx_data_s == CmdWrite) begin
                        state_s    = ADDR;
                        byte_cnt_s = 2'd0;
                    end else if (rx_data_s == CmdGo) begin
                        hold_s = 1'b0;
                    end else if (rx_data_s == CmdHalt) begin
                        hold_s = 1'b1;
                    end else begin
                        hold_s = hold_r;
                    end
                end else if (rx_ferr_s) begin
                    err_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            ADDR, DATA: begin
                if (rx_valid_s) begin
                    byte_cnt_s = byte_cnt_r + 2'd1;
                    // little-endian: first byte ends up in bits [7:0]
                    if (state_r == ADDR) addr_s  = {rx_data_s, addr_r[31:8]};
                    else                 wdata_s = {rx_data_s, wdata_r[31:8]};
                    if (byte_cnt_r == 2'd3) begin
                        state_s = (state_r == ADDR) ? DATA : BUS_REQ;
                        req_s   = (state_r == DATA);
                    end else begin
                        state_s = state_r;
                    end
                end else if (rx_ferr_s || (tmo_r == TmoMax)) begin
                    err_s   = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            BUS_REQ: begin
                if (host_gnt_i) begin
                    req_s   = 1'b0;
                    state_s = BUS_WAIT;
                end else begin
                    req_s = 1'b1;
                end
                if (rx_valid_s || rx_ferr_s) err_s = 1'b1;
                else                         err_s = err_r;
            end
            BUS_WAIT: begin
                if (host_rvalid_i) begin
                    state_s = IDLE;
                    if (host_err_i) err_s = 1'b1;
                    else            err_s = err_r;
                end else begin
                    state_s = BUS_WAIT;
                end
                if (rx_valid_s || rx_ferr_s) err_s = 1'b1;
                else                         err_s = err_s;
            end
            default: begin
                state_s = IDLE;
                req_s   = 1'b0;
            end
        endcase
    end

    assign host_req_o   = req_r;
    assign host_addr_o  = addr_r & 32'hFFFF_FFFC;
    assign host_wdata_o = wdata_r;
    assign host_we_o    = 1'b1;
    assign host_be_o    = 4'hF;
    assign core_hold_o  = hold_r;
    assign err_o        = err_r;

endmodule

// File: tb/tb_uart_bus_loader.sv
// Randomised and directed bench for uart_bus_loader against a byte-level command model.
module tb_uart_bus_loader;
    localparam int Cpb = 10;
    localparam int Tmo = 400;

    logic        clk_sys_i = 1'b0;
    logic        rst_sys_ni = 1'b0;
    logic        uart_rx_i = 1'b1;
    logic        host_req_o, host_we_o, core_hold_o, err_o;
    logic        host_gnt_i = 1'b1, host_rvalid_i = 1'b0, host_err_i = 1'b0;
    logic [31:0] host_addr_o, host_wdata_o;
    logic [3:0]  host_be_o;

    int n_cmp = 0, n_fail = 0;
    int gnt_delay = 0, req_cnt = 0;
    bit resp_err = 1'b0, resp_pend = 1'b0;
    logic [31:0] a0, d0;
    logic [63:0] obs_q[$], exp_q[$];
    logic [7:0]  pend_q[$];
    bit collecting = 1'b0;
    logic exp_hold = 1'b1, exp_err = 1'b0;

    uart_bus_loader #(
        .ClockFrequency(1_000_000), .BaudRate(100_000),
        .TimeoutCycles(Tmo), .HoldAtReset(1'b1)
    ) dut (
        .clk_sys_i(clk_sys_i), .rst_sys_ni(rst_sys_ni), .uart_rx_i(uart_rx_i),
        .host_req_o(host_req_o), .host_gnt_i(host_gnt_i), .host_addr_o(host_addr_o),
        .host_we_o(host_we_o), .host_be_o(host_be_o), .host_wdata_o(host_wdata_o),
        .host_rvalid_i(host_rvalid_i), .host_err_i(host_err_i),
        .core_hold_o(core_hold_o), .err_o(err_o)
    );

    initial forever #5 clk_sys_i = ~clk_sys_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: command semantics at byte granularity.
    task automatic model_byte(input logic [7:0] b, input logic stop_ok);
        logic [31:0] a, d;
        if (!stop_ok) begin
            exp_err = 1'b1;
            collecting = 1'b0;
            pend_q.delete();
        end else if (collecting) begin
            pend_q.push_back(b);
            if (pend_q.size() == 8) begin
                a = {pend_q[3], pend_q[2], pend_q[1], pend_q[0] & 8'hFC};
                d = {pend_q[7], pend_q[6], pend_q[5], pend_q[4]};
                exp_q.push_back({a, d});
                if (resp_err) exp_err = 1'b1;
                collecting = 1'b0;
            end
        end else if (b == 8'h57) begin
            collecting = 1'b1;
            pend_q.delete();
        end else if (b == 8'h47) begin
            exp_hold = 1'b0;
        end else if (b == 8'h48) begin
            exp_hold = 1'b1;
        end
    endtask

    task automatic model_gap(input int cycles);
        if (collecting && cycles > Tmo) begin
            exp_err = 1'b1;
            collecting = 1'b0;
            pend_q.delete();
        end
    endtask

    task automatic model_reset();
        exp_hold = 1'b1; exp_err = 1'b0; collecting = 1'b0;
        pend_q.delete(); exp_q.delete(); obs_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        model_byte(b, stop_bit);
        @(negedge clk_sys_i);
        uart_rx_i = 1'b0;
        repeat (Cpb) @(negedge clk_sys_i);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            repeat (Cpb) @(negedge clk_sys_i);
        end
        uart_rx_i = stop_bit;
        repeat (Cpb) @(negedge clk_sys_i);
        uart_rx_i = 1'b1;
        repeat (3) @(negedge clk_sys_i);
    endtask

    task automatic send_cmd(input logic [31:0] a, input logic [31:0] d);
        send_byte(8'h57, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b1);
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], 1'b1);
    endtask

    task automatic check_writes(input string tag);
        logic [63:0] o, e;
        chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_addr_data"}, o, e);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic write_and_check(input string tag, input logic [31:0] a, input logic [31:0] d);
        send_cmd(a, d);
        repeat (gnt_delay + 20) @(negedge clk_sys_i);
        check_writes(tag);
        chk({tag, "_err"}, 64'(err_o), 64'(exp_err));
    endtask

    // Bus target: programmable grant delay, response one cycle after grant.
    initial begin : responder
        forever begin
            @(negedge clk_sys_i);
            host_rvalid_i = 1'b0;
            host_err_i    = 1'b0;
            if (!rst_sys_ni) begin
                req_cnt = 0;
                resp_pend = 1'b0;
                host_gnt_i = (gnt_delay == 0);
            end else begin
                if (resp_pend) begin
                    host_rvalid_i = 1'b1;
                    host_err_i = resp_err;
                    resp_pend = 1'b0;
                    chk("req_drop_after_gnt", 64'(host_req_o), 64'd0);
                end
                if (host_req_o) begin
                    req_cnt++;
                    if (req_cnt == 1) begin
                        a0 = host_addr_o;
                        d0 = host_wdata_o;
                    end else begin
                        chk("addr_stable", 64'(host_addr_o), 64'(a0));
                        chk("wdata_stable", 64'(host_wdata_o), 64'(d0));
                    end
                    if (req_cnt == gnt_delay + 1) begin
                        host_gnt_i = 1'b1;
                        chk("we", 64'(host_we_o), 64'd1);
                        chk("be", 64'(host_be_o), 64'hF);
                        obs_q.push_back({host_addr_o, host_wdata_o});
                        resp_pend = 1'b1;
                        req_cnt = 0;
                    end else begin
                        host_gnt_i = 1'b0;
                    end
                end else begin
                    if (req_cnt != 0) begin
                        chk("req_held_until_gnt", 64'(host_req_o), 64'd1);
                        req_cnt = 0;
                    end
                    host_gnt_i = (gnt_delay == 0);
                end
            end
        end
    end

    initial begin : main
        logic [7:0] b;
        int waited;
        rst_sys_ni = 1'b0;
        repeat (3) @(negedge clk_sys_i);
        chk("rst_req", 64'(host_req_o), 64'd0);
        chk("rst_addr", 64'(host_addr_o), 64'd0);
        chk("rst_wdata", 64'(host_wdata_o), 64'd0);
        chk("rst_we", 64'(host_we_o), 64'd1);
        chk("rst_be", 64'(host_be_o), 64'hF);
        chk("rst_hold", 64'(core_hold_o), 64'd1);
        chk("rst_err", 64'(err_o), 64'd0);
        rst_sys_ni = 1'b1;
        repeat (3) @(negedge clk_sys_i);

        gnt_delay = 0;
        write_and_check("wr_gnt_tied", 32'h0010_1000, 32'hDEAD_BEEF);
        gnt_delay = 20;
        write_and_check("wr_gnt_wait", 32'h0010_1000, 32'hDEAD_BEEF);
        gnt_delay = 0;

        send_byte(8'h47, 1'b1); repeat (2) @(negedge clk_sys_i);
        chk("hold_after_go", 64'(core_hold_o), 64'(exp_hold));
        send_byte(8'h48, 1'b1); repeat (2) @(negedge clk_sys_i);
        chk("hold_after_halt", 64'(core_hold_o), 64'(exp_hold));
        send_byte(8'h00, 1'b1); repeat (2) @(negedge clk_sys_i);
        chk("hold_after_other", 64'(core_hold_o), 64'(exp_hold));

        send_byte(8'h57, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1);
        repeat (Tmo + 10) @(negedge clk_sys_i);
        model_gap(Tmo + 10);
        check_writes("timeout");
        chk("timeout_err", 64'(err_o), 64'(exp_err));
        write_and_check("wr_after_timeout", 32'h2000_0043, 32'h1234_5678);

        rst_sys_ni = 1'b0; model_reset();
        repeat (2) @(negedge clk_sys_i);
        rst_sys_ni = 1'b1;
        send_byte(8'hA5, 1'b0); repeat (5) @(negedge clk_sys_i);
        check_writes("frame_err");
        chk("frame_err_flag", 64'(err_o), 64'(exp_err));
        send_byte(8'h41, 1'b1);
        write_and_check("wr_after_41", 32'h0000_0F00, 32'hCAFE_F00D);

        rst_sys_ni = 1'b0; model_reset();
        repeat (2) @(negedge clk_sys_i);
        rst_sys_ni = 1'b1;
        resp_err = 1'b1;
        write_and_check("wr_bus_err", 32'h4000_0000, 32'h0BAD_0BAD);
        resp_err = 1'b0;

        gnt_delay = 60;
        send_cmd(32'h5555_0004, 32'hA5A5_A5A5);
        waited = 0;
        while (!host_req_o && waited < 300) begin
            @(negedge clk_sys_i);
            waited++;
        end
        chk("req_before_reset", 64'(host_req_o), 64'd1);
        #1 rst_sys_ni = 1'b0;
        #1;
        chk("async_rst_req", 64'(host_req_o), 64'd0);
        chk("async_rst_err", 64'(err_o), 64'd0);
        chk("async_rst_hold", 64'(core_hold_o), 64'd1);
        model_reset();
        gnt_delay = 0;
        repeat (3) @(negedge clk_sys_i);
        rst_sys_ni = 1'b1;
        repeat (2) @(negedge clk_sys_i);

        for (int it = 0; it < 6; it++) begin
            b = 8'($urandom);
            if (b == 8'h57) b = 8'h00;
            if (it % 2 == 1) b = ($urandom_range(0, 1) == 0) ? 8'h47 : 8'h48;
            send_byte(b, 1'b1);
            repeat (2) @(negedge clk_sys_i);
            chk("rand_hold", 64'(core_hold_o), 64'(exp_hold));
            gnt_delay = $urandom_range(0, 5);
            write_and_check("rand_wr", $urandom, $urandom);
        end
        gnt_delay = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_bus_loader.md
# uart_bus_loader

UART-driven bus host that sits upstream of the demo system bus as an additional host port, next to the core data port and the debug module's system-bus-access port. It receives a byte stream on a UART RX pin, decodes word-write and core-control commands, and issues single-word writes into RAM or peripherals without JTAG. It also drives a hold signal that the top level ANDs into the core reset, so the core stays in reset while software is loaded.

## Interface
Parameters:
- ClockFrequency, 50_000_000: clk_sys_i frequency in Hz.
- BaudRate, 115_200: UART bit rate; ClksPerBit = ClockFrequency / BaudRate (integer division, 434 at defaults).
- TimeoutCycles, 1_000_000: maximum idle gap between bytes of one command.
- HoldAtReset, 1'b1: reset value of core_hold_o.

Ports:
- clk_sys_i  in  1  system clock.
- rst_sys_ni  in  1  reset (decided: rst_sys_ni, asynchronous, active-low; clock clk_sys_i).
- uart_rx_i  in  1  asynchronous UART receive line, idle high.
- host_req_o  out  1  bus request.
- host_gnt_i  in  1  bus grant.
- host_addr_o  out  32  word address; bits [1:0] are always 0.
- host_we_o  out  1  write enable; always 1 while host_req_o is high.
- host_be_o  out  4  byte enables; always 4'hF.
- host_wdata_o  out  32  write data.
- host_rvalid_i  in  1  response valid.
- host_err_i  in  1  response error; sampled only when host_rvalid_i is high.
- core_hold_o  out  1  high: core is held in reset.
- err_o  out  1  sticky error flag; cleared only by reset.

## Operation
- Receiver:
  - uart_rx_i passes through a 2-flop synchroniser.
  - A falling edge in RX_IDLE starts a frame. The start bit is re-checked at ClksPerBit/2; if it reads high, the frame is discarded silently.
  - Data is sampled every ClksPerBit, 8 bits, LSB first.
  - Stop bit is 1: a one-cycle rx_valid pulses with the byte.
  - Stop bit is 0: the byte is dropped, err_o is set, and the parser returns to IDLE.
- Parser FSM:
  - IDLE:
    - 0x57 'W' -> ADDR.
    - 0x47 'G' clears core_hold_o.
    - 0x48 'H' sets core_hold_o.
    - Any other byte is ignored.
  - ADDR: collects 4 bytes, little-endian; the 4th byte -> DATA.
  - DATA: collects 4 bytes, little-endian; the 4th byte -> BUS_REQ.
  - BUS_REQ: host_req_o=1 with stable addr/wdata until host_gnt_i; a grant -> BUS_WAIT and host_req_o drops the next cycle.
  - BUS_WAIT: waits for host_rvalid_i. If host_err_i=1, err_o is set. Either way -> IDLE.
- Inter-byte timeout: in ADDR or DATA, if TimeoutCycles pass without rx_valid, the partial command is discarded, err_o is set, and the FSM -> IDLE.
- A byte arriving in BUS_REQ or BUS_WAIT is dropped and err_o is set.
- Address bits [1:0] received on the wire are ignored and forced to 0.
- Bus writes are independent of core_hold_o: writes are accepted whether the core is held or running.

## Timing
- Reset values:
  - host_req_o=0, host_addr_o=0, host_wdata_o=0, host_we_o=1, host_be_o=4'hF.
  - core_hold_o=HoldAtReset, err_o=0.
  - Parser in IDLE, receiver in RX_IDLE.
- rx_valid is asserted ClksPerBit/2 + 9*ClksPerBit + 2 cycles (±1) after the start-bit falling edge at the pin.
- host_req_o rises the cycle after rx_valid of the 8th payload byte.
- host_req_o and payload are held stable until the cycle host_gnt_i=1.
- Zero-wait-state grant: request and grant occur in the same cycle; host_req_o is low the next cycle.
- core_hold_o changes the cycle after rx_valid of a 'G' or 'H' byte.
- err_o rises the cycle after the error condition.
- Timeout counter: reset on every rx_valid; saturates, no wrap.
- Reset asserted mid-frame or mid-transaction: everything returns to its reset value asynchronously. A pending host_req_o drops immediately, with no completion required.

## Structure
- Package uart_bus_loader_pkg holds:
  - Command byte constants CmdWrite=8'h57, CmdGo=8'h47, CmdHalt=8'h48.
  - Parser state enum {IDLE, ADDR, DATA, BUS_REQ, BUS_WAIT}.
  - Receiver state enum {RX_IDLE, RX_START, RX_DATA, RX_STOP}.
- Sub-module uart_rx (parameter ClksPerBit; ports: clock, reset, rx_i, rx_valid_o, rx_data_o, rx_frame_err_o) holds the synchroniser and bit timing.
- Top module: byte counter, shift registers, timeout counter, parser FSM and bus host logic.

## Test plan
- Bytes 57 00 10 10 00 EF BE AD DE at 115200 baud, gnt tied high, rvalid one cycle later -> one write of addr 0x00101000, wdata 0xDEADBEEF, be 4'hF; err_o stays 0.
- Same write with host_gnt_i held low for 20 cycles -> host_req_o, addr and wdata stable for all 21 cycles; exactly one grant is accepted.
- Out of reset, core_hold_o=1. Send 0x47 -> core_hold_o=0. Then 0x48 -> core_hold_o=1. Byte 0x00 -> no change.
- Send 57 00 10 then a gap of TimeoutCycles+10 -> no bus request; err_o=1. A subsequent full write command still completes correctly.
- Frame with stop bit driven 0 -> err_o=1 and no rx_valid. A 0x41 preceding a valid write -> the write still happens.
- Write with host_rvalid_i and host_err_i both 1 -> err_o=1. Assert rst_sys_ni low during BUS_REQ -> host_req_o=0 and err_o=0 immediately.
